// File: rtl/rvfi_commit_if.sv
// rvfi_commit_if: writeback commit inputs and monitor-facing mon_* bundle
interface rvfi_commit_if;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic [4:0]  wb_rs1_addr, wb_rs2_addr;
  logic [31:0] wb_rs1_rdata, wb_rs2_rdata;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_wdata;
  logic [31:0] wb_pc_rdata, wb_pc_wdata;
  logic [31:0] wb_mem_addr;
  logic [3:0]  wb_mem_rmask, wb_mem_wmask;
  logic [31:0] wb_mem_rdata, wb_mem_wdata;
  logic        mon_valid;
  logic [63:0] mon_order;
  logic [31:0] mon_inst;
  logic [4:0]  mon_rs1_addr, mon_rs2_addr;
  logic [31:0] mon_rs1_rdata, mon_rs2_rdata;
  logic [4:0]  mon_rd_addr;
  logic [31:0] mon_rd_wdata;
  logic [31:0] mon_pc_rdata, mon_pc_wdata;
  logic [31:0] mon_mem_addr;
  logic [3:0]  mon_mem_rmask, mon_mem_wmask;
  logic [31:0] mon_mem_rdata, mon_mem_wdata;
  logic        mon_halt;
  logic        mon_error;
  modport master (
    output wb_valid, wb_inst, wb_rs1_addr, wb_rs2_addr, wb_rs1_rdata, wb_rs2_rdata,
           wb_rd_addr, wb_rd_wdata, wb_pc_rdata, wb_pc_wdata, wb_mem_addr,
           wb_mem_rmask, wb_mem_wmask, wb_mem_rdata, wb_mem_wdata,
    input  mon_valid, mon_order, mon_inst, mon_rs1_addr, mon_rs2_addr, mon_rs1_rdata,
           mon_rs2_rdata, mon_rd_addr, mon_rd_wdata, mon_pc_rdata, mon_pc_wdata,
           mon_mem_addr, mon_mem_rmask, mon_mem_wmask, mon_mem_rdata, mon_mem_wdata,
           mon_halt, mon_error
  );
  modport slave (
    input  wb_valid, wb_inst, wb_rs1_addr, wb_rs2_addr, wb_rs1_rdata, wb_rs2_rdata,
           wb_rd_addr, wb_rd_wdata, wb_pc_rdata, wb_pc_wdata, wb_mem_addr,
           wb_mem_rmask, wb_mem_wmask, wb_mem_rdata, wb_mem_wdata,
    output mon_valid, mon_order, mon_inst, mon_rs1_addr, mon_rs2_addr, mon_rs1_rdata,
           mon_rs2_rdata, mon_rd_addr, mon_rd_wdata, mon_pc_rdata, mon_pc_wdata,
           mon_mem_addr, mon_mem_rmask, mon_mem_wmask, mon_mem_rdata, mon_mem_wdata,
           mon_halt, mon_error
  );
endinterface

// File: rtl/rvfi_commit_driver.sv
// rvfi_commit_driver: registers, numbers and normalises retiring instructions onto the monitor bundle
module rvfi_commit_driver #(
  parameter logic [31:0] HALT_INST = 32'h0000006f,
  parameter bit          CHECK_PC  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  rvfi_commit_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;
  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] inst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, pc_rdata, pc_wdata, mem_addr;
    logic [3:0]  rmask, wmask;
    logic [31:0] mem_rdata, mem_wdata;
    logic        halt, error;
  } mon_t;
  state_t      state, state_n;
  mon_t        q, nx;
  logic [63:0] cnt;
  logic [31:0] prev_pc;
  logic        prev_v, accept, halt, hit;
  // A mask is legal when it is byte/half/word shaped and its lowest lane matches the address offset
  function automatic logic mask_ok(input logic [3:0] m, input logic [1:0] a);
    logic [1:0] lo;
    lo = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
    return m == 4'd0 || (m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hc, 4'hf} && lo == a);
  endfunction
  // State register: HALTED is left only through reset
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;
  // Accept, halt and protocol checks; build the next normalised mon_* word (zero when idle)
  always_comb begin
    accept = state == RUN && bus.wb_valid;
    halt = bus.wb_inst == HALT_INST || bus.wb_pc_wdata == bus.wb_pc_rdata;
    hit = (bus.wb_mem_rmask != 4'd0 && bus.wb_mem_wmask != 4'd0)
      || !mask_ok(bus.wb_mem_rmask, bus.wb_mem_addr[1:0])
      || !mask_ok(bus.wb_mem_wmask, bus.wb_mem_addr[1:0])
      || (CHECK_PC && prev_v && bus.wb_pc_rdata != prev_pc);
    state_n = accept && halt ? HALTED : state;
    nx = '0;
    nx.error = q.error | (accept & hit);
    if (accept) begin
      nx.valid = 1'b1;
      nx.order = cnt;
      nx.inst = bus.wb_inst;
      nx.rs1_addr = bus.wb_rs1_addr;
      nx.rs2_addr = bus.wb_rs2_addr;
      nx.rs1_rdata = bus.wb_rs1_addr != 5'd0 ? bus.wb_rs1_rdata : 32'd0;
      nx.rs2_rdata = bus.wb_rs2_addr != 5'd0 ? bus.wb_rs2_rdata : 32'd0;
      nx.rd_addr = bus.wb_rd_addr;
      nx.rd_wdata = bus.wb_rd_addr != 5'd0 ? bus.wb_rd_wdata : 32'd0;
      nx.pc_rdata = bus.wb_pc_rdata;
      nx.pc_wdata = bus.wb_pc_wdata;
      nx.mem_addr = (bus.wb_mem_rmask | bus.wb_mem_wmask) != 4'd0 ? bus.wb_mem_addr : 32'd0;
      nx.rmask = bus.wb_mem_rmask;
      nx.wmask = bus.wb_mem_wmask;
      nx.mem_rdata = bus.wb_mem_rmask != 4'd0 ? bus.wb_mem_rdata : 32'd0;
      nx.mem_wdata = bus.wb_mem_wmask != 4'd0 ? bus.wb_mem_wdata : 32'd0;
      nx.halt = halt;
    end
  end
  // Output register, retire counter and PC-continuity history
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q <= '0;
      cnt <= '0;
      prev_pc <= '0;
      prev_v <= 1'b0;
    end else begin
      q <= nx;
      if (accept) begin
        cnt <= cnt + 64'd1;
        prev_pc <= bus.wb_pc_wdata;
        prev_v <= 1'b1;
      end
    end
  assign bus.mon_valid = q.valid;
  assign bus.mon_order = q.order;
  assign bus.mon_inst = q.inst;
  assign bus.mon_rs1_addr = q.rs1_addr;
  assign bus.mon_rs2_addr = q.rs2_addr;
  assign bus.mon_rs1_rdata = q.rs1_rdata;
  assign bus.mon_rs2_rdata = q.rs2_rdata;
  assign bus.mon_rd_addr = q.rd_addr;
  assign bus.mon_rd_wdata = q.rd_wdata;
  assign bus.mon_pc_rdata = q.pc_rdata;
  assign bus.mon_pc_wdata = q.pc_wdata;
  assign bus.mon_mem_addr = q.mem_addr;
  assign bus.mon_mem_rmask = q.rmask;
  assign bus.mon_mem_wmask = q.wmask;
  assign bus.mon_mem_rdata = q.mem_rdata;
  assign bus.mon_mem_wdata = q.mem_wdata;
  assign bus.mon_halt = q.halt;
  assign bus.mon_error = q.error;
endmodule

// File: tb/tb_rvfi_commit_driver.sv
// tb_rvfi_commit_driver: directed and random commit streams checked against a reference model
module tb_rvfi_commit_driver;
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  rs1a, rs2a;
    logic [31:0] rs1d, rs2d;
    logic [4:0]  rda;
    logic [31:0] rdd, pcr, pcw, addr;
    logic [3:0]  rm, wm;
    logic [31:0] rdata, wdata;
  } cmt_t;
  logic clk = 1'b0, rst = 1'b1;
  cmt_t cur = '0;
  int total = 0, bad = 0;
  logic        m_halted, m_prev_v, m_err;
  logic [63:0] m_cnt;
  logic [31:0] m_prev_pc, npc;
  logic        e_valid, e_halt, e_err;
  logic [63:0] e_order;
  logic [310:0] e_data;
  rvfi_commit_if bus();
  rvfi_commit_driver dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.wb_valid = cur.valid;
  assign bus.wb_inst = cur.inst;
  assign bus.wb_rs1_addr = cur.rs1a;
  assign bus.wb_rs2_addr = cur.rs2a;
  assign bus.wb_rs1_rdata = cur.rs1d;
  assign bus.wb_rs2_rdata = cur.rs2d;
  assign bus.wb_rd_addr = cur.rda;
  assign bus.wb_rd_wdata = cur.rdd;
  assign bus.wb_pc_rdata = cur.pcr;
  assign bus.wb_pc_wdata = cur.pcw;
  assign bus.wb_mem_addr = cur.addr;
  assign bus.wb_mem_rmask = cur.rm;
  assign bus.wb_mem_wmask = cur.wm;
  assign bus.wb_mem_rdata = cur.rdata;
  assign bus.wb_mem_wdata = cur.wdata;
  function automatic bit legal(logic [3:0] m, logic [1:0] a);
    return m == 4'd0 || m == (4'b0001 << a) || (!a[0] && m == (4'b0011 << a)) || (a == 2'd0 && m == 4'hf);
  endfunction
  function automatic logic [310:0] norm(cmt_t c);
    return {c.inst, c.rs1a, c.rs2a, c.rs1a == 5'd0 ? 32'd0 : c.rs1d, c.rs2a == 5'd0 ? 32'd0 : c.rs2d,
            c.rda, c.rda == 5'd0 ? 32'd0 : c.rdd, c.pcr, c.pcw,
            (c.rm == 4'd0 && c.wm == 4'd0) ? 32'd0 : c.addr, c.rm, c.wm,
            c.rm == 4'd0 ? 32'd0 : c.rdata, c.wm == 4'd0 ? 32'd0 : c.wdata};
  endfunction
  function automatic cmt_t base(logic [31:0] pc);
    cmt_t c;
    c = '0;
    c.valid = 1'b1;
    c.inst = 32'h00000013;
    c.rs1a = 5'd1; c.rs2a = 5'd2; c.rs1d = 32'h11; c.rs2d = 32'h22;
    c.rda = 5'd3; c.rdd = 32'h33;
    c.pcr = pc; c.pcw = pc + 32'd4;
    c.rdata = 32'h55aa55aa; c.wdata = 32'haa55aa55;
    return c;
  endfunction
  task automatic m_reset();
    m_halted = 0; m_prev_v = 0; m_err = 0; m_cnt = '0; m_prev_pc = '0;
    e_valid = 0; e_halt = 0; e_err = 0; e_order = '0; e_data = '0;
  endtask
  task automatic model();
    logic h, b;
    if (rst) begin
      m_reset();
      return;
    end
    if (!m_halted && cur.valid) begin
      h = cur.inst == 32'h0000006f || cur.pcw == cur.pcr;
      b = (cur.rm != 0 && cur.wm != 0) || !legal(cur.rm, cur.addr[1:0]) || !legal(cur.wm, cur.addr[1:0])
        || (m_prev_v && cur.pcr != m_prev_pc);
      m_err = m_err | b;
      e_valid = 1; e_order = m_cnt; e_halt = h; e_data = norm(cur);
      m_cnt = m_cnt + 1;
      m_prev_pc = cur.pcw; m_prev_v = 1;
      if (h) m_halted = 1;
    end else begin
      e_valid = 0; e_order = '0; e_halt = 0; e_data = '0;
    end
    e_err = m_err;
  endtask
  task automatic chk(string tag, logic [319:0] obs, logic [319:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, "_valid"}, 320'(bus.mon_valid), 320'(e_valid));
    chk({tag, "_order"}, 320'(bus.mon_order), 320'(e_order));
    chk({tag, "_halt"}, 320'(bus.mon_halt), 320'(e_halt));
    chk({tag, "_error"}, 320'(bus.mon_error), 320'(e_err));
    chk({tag, "_data"}, 320'({bus.mon_inst, bus.mon_rs1_addr, bus.mon_rs2_addr, bus.mon_rs1_rdata,
        bus.mon_rs2_rdata, bus.mon_rd_addr, bus.mon_rd_wdata, bus.mon_pc_rdata, bus.mon_pc_wdata,
        bus.mon_mem_addr, bus.mon_mem_rmask, bus.mon_mem_wmask, bus.mon_mem_rdata, bus.mon_mem_wdata}),
        320'(e_data));
  endtask
  task automatic step(string tag);
    @(posedge clk);
    model();
    #1;
    check_all(tag);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 m_reset();
    check_all("async_rst");
    @(posedge clk);
    model();
    #1;
    check_all("rst_hold");
    #2 rst = 1'b0;
  endtask
  task automatic rnd(output cmt_t c);
    logic [31:0] r;
    logic [1:0]  a;
    logic [3:0]  m;
    int k, sz;
    c = '0;
    c.valid = $urandom_range(0, 9) < 7;
    c.inst = $urandom;
    if (c.inst == 32'h0000006f) c.inst = 32'h00000013;
    if ($urandom_range(0, 39) == 0) c.inst = 32'h0000006f;
    r = $urandom;
    c.pcr = $urandom_range(0, 39) == 0 ? {r[31:2], 2'b00} : npc;
    c.pcw = $urandom_range(0, 3) == 0 ? c.pcr + 32'(8 * $urandom_range(1, 100)) : c.pcr + 32'd4;
    c.rs1a = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
    c.rs2a = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
    c.rda = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
    c.rs1d = $urandom; c.rs2d = $urandom; c.rdd = $urandom;
    c.rdata = $urandom; c.wdata = $urandom;
    sz = $urandom_range(0, 2);
    a = sz == 0 ? 2'($urandom) : sz == 1 ? {1'($urandom), 1'b0} : 2'd0;
    m = sz == 0 ? 4'b0001 << a : sz == 1 ? 4'b0011 << a : 4'hf;
    r = $urandom;
    c.addr = {r[31:2], a};
    k = $urandom_range(0, 19);
    if (k < 9) c.rm = m;
    else if (k < 17) c.wm = m;
    else if (k == 19) begin
      c.rm = 4'($urandom);
      c.wm = 4'($urandom);
    end
    if (c.valid) npc = c.pcw;
  endtask
  initial begin
    m_reset();
    step("reset0");
    step("reset1");
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur = base(32'h1000 + 32'(4 * i));
      step("seq");
      chk("seq_order_const", 320'(bus.mon_order), 320'(i));
      chk("seq_valid_const", 320'(bus.mon_valid), 320'(1));
      chk("seq_error_const", 320'(bus.mon_error), 320'(0));
    end
    cur = base(32'h100c);
    cur.rda = 5'd0; cur.rdd = 32'hdeadbeef; cur.addr = 32'h40;
    step("norm");
    chk("norm_rd_wdata", 320'(bus.mon_rd_wdata), 320'(0));
    chk("norm_mem_addr", 320'(bus.mon_mem_addr), 320'(0));
    cur = base(32'h1010);
    cur.rm = 4'b1100; cur.addr = 32'h82;
    step("load_half");
    chk("load_half_err", 320'(bus.mon_error), 320'(0));
    cur.valid = 1'b0;
    step("idle");
    cur = base(32'h1014);
    cur.inst = 32'h0000006f;
    step("halt");
    chk("halt_flag", 320'(bus.mon_halt), 320'(1));
    cur = base(32'h1018);
    for (int i = 0; i < 5; i++) begin
      step("halted");
      chk("halted_valid", 320'(bus.mon_valid), 320'(0));
    end
    do_reset();
    cur = base(32'h1ffc);
    step("pc_a");
    chk("restart_order", 320'(bus.mon_order), 320'(0));
    cur = base(32'h2004);
    step("pc_b");
    chk("pc_break_err", 320'(bus.mon_error), 320'(1));
    cur.valid = 1'b0;
    step("pc_sticky");
    chk("pc_sticky_err", 320'(bus.mon_error), 320'(1));
    do_reset();
    cur = base(32'h4000);
    cur.wm = 4'b0110; cur.addr = 32'h101;
    step("bad_store");
    chk("bad_store_err", 320'(bus.mon_error), 320'(1));
    for (int e = 0; e < 6; e++) begin
      cur = base(32'h8000);
      do_reset();
      npc = $urandom & 32'hfffffffc;
      for (int i = 0; i < 80; i++) begin
        rnd(cur);
        step("rand");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
